hc595_chain_driver: RTL and testbench

Serialises a parallel LED/indicator word into a daisy-chain of N SN74HC595 shift registers. It sits directly downstream of the traffic-light top-level. The top-level presents the concatenated lamp bits for both approaches (R/Y/G, through and left-turn) with a valid/ready handshake. This block generates the serial data, shift clock and storage-register (refresh) clock, with a programmable bit period.

---
 rtl/hc595_chain_driver_pkg.sv | 28 ++
 rtl/hc595_chain_driver_bit_timer.sv | 42 ++++
 rtl/hc595_chain_driver.sv | 168 ++++++++++++++++
 tb/tb_hc595_chain_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_chain_driver_pkg.sv
// hc595_chain_driver_pkg
//   Shared definitions for the SN74HC595 chain driver:
//   - FSM state encoding (3-bit codes and the enum built from them)
//   - device width (bits per '595)
//   - helper to size a frame from a device count
package hc595_chain_driver_pkg;

  localparam int DEV_WIDTH = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_LATCH_HI = 3'd3;
  localparam logic [2:0] ST_LATCH_LO = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SHIFT_LO = ST_SHIFT_LO,
    SHIFT_HI = ST_SHIFT_HI,
    LATCH_HI = ST_LATCH_HI,
    LATCH_LO = ST_LATCH_LO
  } state_e;

  function automatic int frame_bits(input int n_devices);
    return DEV_WIDTH * n_devices;
  endfunction

endpackage

// File: rtl/hc595_chain_driver_bit_timer.sv
// hc595_bit_timer
//   Phase divider shared by every FSM state. Counts 0..CLK_DIV-1 and
//   returns to 0 after the terminal count, so each state that waits for
//   o_tc lasts exactly CLK_DIV cycles. i_clear holds the count at 0.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   i_clear  force count to 0 (used while idle)
//   o_tc     terminal count: high in the last cycle of a phase
module hc595_bit_timer #(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tc
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign o_tc = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q + 1'b1;
    if (i_clear || o_tc) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver
//   Serialises an 8*N_BYTES-bit lamp word into a daisy chain of
//   SN74HC595 devices: serial data, shift clock and storage clock, each
//   phase lasting CLK_DIV system clocks.
// Ports:
//   clk                    system clock
//   rst_n                  asynchronous active-low reset (aborts a frame)
//   i_buf                  frame to display, sampled on accept
//   i_valid                frame request (accepted when o_ready is high)
//   o_ready                idle and able to accept
//   o_done                 one-cycle pulse as the frame completes
//   SN74HC595_data         DS
//   SN74HC595_data_clk     SHCP (shift on rising edge)
//   SN74HC595_refresh_clk  STCP (latch on rising edge)
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | ready, all serial outputs low
// SHIFT_LO | SHCP low, DS presents the head bit
// SHIFT_HI | SHCP high, DS held; advance or finish after the phase
// LATCH_HI | STCP high, SHCP and DS low
// LATCH_LO | STCP low; return to IDLE with o_done
module hc595_chain_driver
  import hc595_chain_driver_pkg::*;
#(
  parameter int N_BYTES   = 2,
  parameter int CLK_DIV   = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DEV_WIDTH*N_BYTES-1:0]   i_buf,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic                           o_done,
  output logic                           SN74HC595_data,
  output logic                           SN74HC595_data_clk,
  output logic                           SN74HC595_refresh_clk
);

  localparam int W    = frame_bits(N_BYTES);
  localparam int BW   = $clog2(W);
  localparam int HEAD = MSB_FIRST ? W - 1 : 0;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          data_q, data_d;
  logic          dclk_q, dclk_d;
  logic          rclk_q, rclk_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          phase_tc;

  hc595_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (state_q == IDLE),
    .o_tc    (phase_tc)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    dclk_d    = dclk_q;
    rclk_d    = rclk_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        data_d  = 1'b0;
        dclk_d  = 1'b0;
        rclk_d  = 1'b0;
        if (i_valid) begin
          sr_d      = i_buf;
          bit_cnt_d = LAST_BIT;
          data_d    = i_buf[HEAD];
          ready_d   = 1'b0;
          state_d   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (phase_tc) begin
          dclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (phase_tc) begin
          dclk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            rclk_d  = 1'b1;
            data_d  = 1'b0;
            state_d = LATCH_HI;
          end else begin
            // The next head bit changes on the same edge SHCP falls, so it
            // has a full low phase of setup before the following rise.
            sr_d      = MSB_FIRST ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
            bit_cnt_d = bit_cnt_q - 1'b1;
            data_d    = sr_d[HEAD];
            state_d   = SHIFT_LO;
          end
        end
      end

      LATCH_HI: begin
        if (phase_tc) begin
          rclk_d  = 1'b0;
          state_d = LATCH_LO;
        end
      end

      LATCH_LO: begin
        if (phase_tc) begin
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        data_d  = 1'b0;
        dclk_d  = 1'b0;
        rclk_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      data_q    <= 1'b0;
      dclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      dclk_q    <= dclk_d;
      rclk_q    <= rclk_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign o_ready               = ready_q;
  assign o_done                = done_q;
  assign SN74HC595_data        = data_q;
  assign SN74HC595_data_clk    = dclk_q;
  assign SN74HC595_refresh_clk = rclk_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver. Instance 0: N_BYTES=2, CLK_DIV=2, MSB first.
// Instance 1: N_BYTES=2, CLK_DIV=1, LSB first. A model of two chained '595s
// per instance shifts DS on SHCP rises and latches on STCP rises. For the
// LSB-first chain the lamp wiring is reversed, so its frame view is the
// bit-reversed storage register.
module tb_hc595_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ibuf  [2];
  logic        valid [2];
  logic        ready [2];
  logic        done  [2];
  logic        data  [2];
  logic        dclk  [2];
  logic        rclk  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hc595_chain_driver #(.N_BYTES(2), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_buf                 (ibuf[0]),
    .i_valid               (valid[0]),
    .o_ready               (ready[0]),
    .o_done                (done[0]),
    .SN74HC595_data        (data[0]),
    .SN74HC595_data_clk    (dclk[0]),
    .SN74HC595_refresh_clk (rclk[0])
  );

  hc595_chain_driver #(.N_BYTES(2), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_buf                 (ibuf[1]),
    .i_valid               (valid[1]),
    .o_ready               (ready[1]),
    .o_done                (done[1]),
    .SN74HC595_data        (data[1]),
    .SN74HC595_data_clk    (dclk[1]),
    .SN74HC595_refresh_clk (rclk[1])
  );

  // '595 chain model plus edge counters and DS stability checks
  logic [15:0] chain   [2] = '{16'h0, 16'h0};
  logic [15:0] latched [2] = '{16'h0, 16'h0};
  int          dclk_rises [2] = '{0, 0};
  int          rclk_rises [2] = '{0, 0};
  int          stab_err   [2] = '{0, 0};
  logic        prev_dclk  [2] = '{1'b0, 1'b0};
  logic        prev_rclk  [2] = '{1'b0, 1'b0};
  logic        prev_data  [2] = '{1'b0, 1'b0};
  logic        rise_data  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (dclk[k] && !prev_dclk[k]) begin
          dclk_rises[k] = dclk_rises[k] + 1;
          chain[k]      = {chain[k][14:0], data[k]};
          if (data[k] !== prev_data[k]) stab_err[k] = stab_err[k] + 1;
          rise_data[k] = data[k];
        end
        if (!dclk[k] && prev_dclk[k] && (prev_data[k] !== rise_data[k]))
          stab_err[k] = stab_err[k] + 1;
        if (rclk[k] && !prev_rclk[k]) begin
          rclk_rises[k] = rclk_rises[k] + 1;
          latched[k]    = chain[k];
        end
      end
      prev_dclk[k] = dclk[k];
      prev_rclk[k] = rclk[k];
      prev_data[k] = data[k];
    end
  end

  function automatic logic [15:0] view(input int k);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = latched[k][15-i];
    return (k == 0) ? latched[k] : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int d0, r0, s0;

  task automatic snap(input int k);
    d0 = dclk_rises[k];
    r0 = rclk_rises[k];
    s0 = stab_err[k];
  endtask

  // Drive a request and return #1 after the accept edge
  task automatic start_frame(input int k, input logic [15:0] v, input bit hold);
    @(negedge clk);
    ibuf[k]  = v;
    valid[k] = 1'b1;
    snap(k);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until o_done is seen
  task automatic wait_done(input int k, output int cyc, output int busy);
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    busy = ready[k] ? 0 : 1;
    while (!seen && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done[k]) seen = 1'b1;
      else if (!ready[k]) busy++;
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    int          k;
    logic [15:0] frame;
    logic [15:0] exp_view;
    int          exp_cyc;
    int          exp_dclk;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc, busy;
    logic [15:0] keep;

    // busy = (16*2+2)*CLK_DIV: 68 for CLK_DIV=2, 34 for CLK_DIV=1
    vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 68, 16};
    vecs[1] = '{0, 16'h0000, 16'h0000, 68, 16};
    vecs[2] = '{0, 16'h8001, 16'h8001, 68, 16};
    vecs[3] = '{1, 16'h0001, 16'h0001, 34, 16};
    vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 34, 16};
    vecs[5] = '{1, 16'h1234, 16'h1234, 34, 16};

    for (int k = 0; k < 2; k++) begin
      ibuf[k]  = 16'h0;
      valid[k] = 1'b0;
    end

    // reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready[0]}, 32'd1);
    check("rst_done",  {31'd0, done[0]},  32'd0);
    check("rst_data",  {31'd0, data[0]},  32'd0);
    check("rst_dclk",  {31'd0, dclk[0]},  32'd0);
    check("rst_rclk",  {31'd0, rclk[0]},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap(0);
    repeat (100) @(negedge clk);
    check("idle_ready", {31'd0, ready[0]}, 32'd1);
    check("idle_dclk_edges", dclk_rises[0] - d0, 32'd0);
    check("idle_rclk_edges", rclk_rises[0] - r0, 32'd0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].k, vecs[i].frame, 1'b0);
      wait_done(vecs[i].k, cyc, busy);
      check("vec_done_cycle", cyc, vecs[i].exp_cyc);
      check("vec_busy_len", busy, vecs[i].exp_cyc);
      check("vec_latched", {16'd0, view(vecs[i].k)}, {16'd0, vecs[i].exp_view});
      check("vec_dclk_rises", dclk_rises[vecs[i].k] - d0, vecs[i].exp_dclk);
      check("vec_rclk_rises", rclk_rises[vecs[i].k] - r0, 32'd1);
      check("vec_data_stable", stab_err[vecs[i].k] - s0, 32'd0);
      repeat (3) @(negedge clk);
    end

    // busy ignore + back-to-back accept on the o_done cycle
    start_frame(0, 16'hA5C3, 1'b1);
    ibuf[0] = 16'h0F0F;
    wait_done(0, cyc, busy);
    check("hold_done_cycle", cyc, 32'd68);
    check("hold_latched_first", {16'd0, view(0)}, 32'h0000A5C3);
    snap(0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    check("b2b_accepted", {31'd0, ready[0]}, 32'd0);
    check("b2b_done_single", {31'd0, done[0]}, 32'd0);
    wait_done(0, cyc, busy);
    check("b2b_done_cycle", cyc, 32'd68);
    check("b2b_latched_second", {16'd0, view(0)}, 32'h00000F0F);
    check("b2b_dclk_rises", dclk_rises[0] - d0, 32'd16);
    check("b2b_rclk_rises", rclk_rises[0] - r0, 32'd1);
    repeat (3) @(negedge clk);

    // reset mid-frame after 5 shift-clock rises
    keep = view(0);
    start_frame(0, 16'h3C3C, 1'b0);
    cyc = 0;
    while ((dclk_rises[0] - d0) < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach5", dclk_rises[0] - d0, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", {31'd0, data[0]}, 32'd0);
    check("midrst_dclk", {31'd0, dclk[0]}, 32'd0);
    check("midrst_rclk", {31'd0, rclk[0]}, 32'd0);
    check("midrst_ready", {31'd0, ready[0]}, 32'd1);
    check("midrst_done", {31'd0, done[0]}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_refresh", rclk_rises[0] - r0, 32'd0);
    check("midrst_latched_kept", {16'd0, view(0)}, {16'd0, keep});
    check("midrst_ready_after", {31'd0, ready[0]}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
